// File: rtl/alarm_ctrl_if.sv
// rtl/alarm_ctrl_if.sv - button/time inputs and alarm status outputs of alarm_ctrl
interface alarm_ctrl_if;
  logic        en;
  logic [15:0] time_hm;
  logic [15:0] alarm_hm;
  logic        sec_tick;
  logic        min_tick;
  logic        snooze;
  logic        dismiss;
  logic        ringing;
  logic        buzz;
  logic        snoozing;
  logic [1:0]  state;
  logic [2:0]  snooze_left;

  // Clock core / buttons side: drives time, ticks and button pulses, observes status.
  modport master (
    output en, time_hm, alarm_hm, sec_tick, min_tick, snooze, dismiss,
    input  ringing, buzz, snoozing, state, snooze_left
  );

  // Alarm controller side.
  modport slave (
    input  en, time_hm, alarm_hm, sec_tick, min_tick, snooze, dismiss,
    output ringing, buzz, snoozing, state, snooze_left
  );
endinterface

// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - alarm compare, ring timeout and snooze state machine
module alarm_ctrl #(
  parameter int SNOOZE_MIN   = 9,
  parameter int RING_MAX_MIN = 10,
  parameter int MAX_SNOOZE   = 3
) (
  input  logic         clk,
  input  logic         rst_btn,
  alarm_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RING   = 2'b01,
    ST_SNOOZE = 2'b10
  } state_e;

  localparam logic [5:0] SNZ_INIT  = 6'(SNOOZE_MIN);
  localparam logic [5:0] RING_MAX  = 6'(RING_MAX_MIN);
  localparam logic [2:0] LEFT_INIT = 3'(MAX_SNOOZE);

  logic       rst_meta_q;
  logic       rst_n_q;

  state_e     state_q,    state_d;
  logic       phase_q,    phase_d;
  logic       fired_q,    fired_d;
  logic [5:0] ring_cnt_q, ring_cnt_d;
  logic [5:0] snz_cnt_q,  snz_cnt_d;
  logic [2:0] left_q,     left_d;
  logic       ringing_q,  ringing_d;
  logic       snoozing_q, snoozing_d;
  logic       buzz_q,     buzz_d;

  logic       match;
  logic [5:0] ring_inc;

  assign match    = (bus.time_hm == bus.alarm_hm);
  assign ring_inc = ring_cnt_q + 6'd1;

  // Reset synchronizer: the board pin clears everything at once, release waits two clk edges.
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      rst_meta_q <= 1'b0;
      rst_n_q    <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n_q    <= rst_meta_q;
    end
  end

  // State register plus registered outputs.
  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      state_q    <= ST_IDLE;
      phase_q    <= 1'b0;
      fired_q    <= 1'b0;
      ring_cnt_q <= 6'd0;
      snz_cnt_q  <= 6'd0;
      left_q     <= LEFT_INIT;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
      buzz_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      fired_q    <= fired_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      left_q     <= left_d;
      ringing_q  <= ringing_d;
      snoozing_q <= snoozing_d;
      buzz_q     <= buzz_d;
    end
  end

  // Next-state logic; entry rules set phase, so a coincident sec_tick never toggles it on entry.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    fired_d    = fired_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    left_d     = left_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.en && match && !fired_q) begin
          state_d    = ST_RING;
          ring_cnt_d = 6'd0;
          phase_d    = 1'b1;
          left_d     = LEFT_INIT;
          fired_d    = 1'b1;
        end
      end
      ST_RING: begin
        if (!bus.en || bus.dismiss) begin
          state_d = ST_IDLE;
        end else if (bus.snooze && (left_q != 3'd0)) begin
          state_d   = ST_SNOOZE;
          snz_cnt_d = SNZ_INIT;
          left_d    = left_q - 3'd1;
        end else begin
          if (bus.min_tick) begin
            ring_cnt_d = ring_inc;
            if (ring_inc == RING_MAX) begin
              state_d = ST_IDLE;
            end
          end
          if (bus.sec_tick && (state_d == ST_RING)) begin
            phase_d = ~phase_q;
          end
        end
      end
      ST_SNOOZE: begin
        if (!bus.en || bus.dismiss) begin
          state_d = ST_IDLE;
        end else if (bus.min_tick) begin
          snz_cnt_d = snz_cnt_q - 6'd1;
          if (snz_cnt_q == 6'd1) begin
            state_d    = ST_RING;
            ring_cnt_d = 6'd0;
            phase_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Re-arming only happens once the alarm minute has passed.
    if (!match) begin
      fired_d = 1'b0;
    end
  end

  // Output decode from next state so the registered outputs line up with state_q.
  always_comb begin
    ringing_d  = (state_d == ST_RING);
    snoozing_d = (state_d == ST_SNOOZE);
    buzz_d     = (state_d == ST_RING) && phase_d;
  end

  assign bus.ringing     = ringing_q;
  assign bus.snoozing    = snoozing_q;
  assign bus.buzz        = buzz_q;
  assign bus.state       = state_q;
  assign bus.snooze_left = left_q;

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
Downstream consumer of the clock core. Compares the running time {hour,min} against the stored alarm time and drives the alarm output with ring-timeout and snooze handling. Sits between the clock/alarm-set counters and the LED/buzzer pins; takes its buttons from the existing DebouncePed pulses.

Parameters:
SNOOZE_MIN, 9, minutes spent in snooze before re-ringing (1..63)
RING_MAX_MIN, 10, minutes of unattended ringing before auto-stop (1..63)
MAX_SNOOZE, 3, snoozes allowed per alarm event; further snooze presses are ignored (0..7)

Ports:
clk  in  1  system clock (100 MHz)
rst_btn  in  1  asynchronous reset, active-low; connected straight to the board reset pin, not to the inverted internal rst
en  in  1  alarm armed (switch level)
time_hm  in  16  current time {hour[7:0], min[7:0]}, binary
alarm_hm  in  16  alarm time {hour[7:0], min[7:0]}, binary
sec_tick  in  1  one-cycle pulse per second
min_tick  in  1  one-cycle pulse per minute rollover (the seconds counter's zC)
snooze  in  1  one-cycle debounced pulse
dismiss  in  1  one-cycle debounced pulse
ringing  out  1  high in RING state
buzz  out  1  ringing AND 1 Hz phase (toggles each sec_tick)
snoozing  out  1  high in SNOOZE state
state  out  2  00 IDLE, 01 RING, 10 SNOOZE (11 unused)
snooze_left  out  3  snoozes remaining

Behaviour:
- All state and outputs are registered. rst_btn low → state IDLE, ringing=0, buzz=0, snoozing=0, phase=0, fired=0, ring_cnt=0, snz_cnt=0, snooze_left=MAX_SNOOZE. Assertion is immediate; release is synchronous to clk.
- match = (time_hm == alarm_hm) over all 16 bits, combinational.
- fired flag: set when entering RING from IDLE. Cleared on any cycle with match=0. This prevents re-trigger within the alarm minute after dismiss or timeout.
- IDLE:
  - en & match & ~fired → RING on next edge.
  - On that entry: ring_cnt=0, phase=1 (buzz high on first RING cycle), snooze_left=MAX_SNOOZE.
- RING (events checked in priority order):
  - ~en or dismiss → IDLE.
  - else snooze & snooze_left≠0 → SNOOZE; snz_cnt=SNOOZE_MIN; snooze_left−1.
  - else min_tick: ring_cnt+1; if ring_cnt+1==RING_MAX_MIN → IDLE.
  - sec_tick toggles phase.
  - A snooze with snooze_left==0 is ignored; ringing continues.
- SNOOZE:
  - ~en or dismiss → IDLE.
  - else min_tick: snz_cnt−1; if that makes it 0 → RING with ring_cnt=0, phase=1.
  - snooze presses have no effect here.
- Simultaneous events:
  - dismiss beats snooze.
  - snooze beats min_tick/timeout in the same cycle.
  - sec_tick together with a state change: phase is set by the entry rule, not toggled.
- Outputs:
  - ringing = (state==RING).
  - snoozing = (state==SNOOZE).
  - buzz = ringing & phase, registered. buzz is 0 in IDLE and SNOOZE.
- Leaving RING/SNOOZE for IDLE does not clear fired. Re-arm needs match to drop.
- Changing alarm_hm or time_hm during RING/SNOOZE does not abort the event; only en/dismiss/timeout end it.
- Counter widths: ring_cnt and snz_cnt are 6 bits, snooze_left is 3 bits. No wrap is reachable within the legal parameter ranges.

Test Plan:
- Reset mid-RING: force RING, pull rst_btn low asynchronously → all outputs 0 before the next clk edge, state=00.
- Basic trigger: alarm_hm=0x0715, en=1, time_hm steps 0x0714→0x0715 → state=01 one cycle later, buzz=1 then toggles on each sec_tick. Dismiss → IDLE. Further sec/min ticks with time still 0x0715 → no re-ring. Time 0x0716 then alarm set back to 0x0716 → rings again.
- Timeout: ring with RING_MAX_MIN=10, no buttons → IDLE exactly on the 10th min_tick after entry; ringing=0 the cycle after.
- Snooze cycle: ring, press snooze → state=10, snooze_left=2. 9 min_ticks → back to 01 on the 9th. Repeat until snooze_left=0; the fourth snooze press is ignored and state stays 01.
- Priority: snooze & dismiss in the same cycle → IDLE. snooze & min_tick on the 10th ring minute → SNOOZE, not IDLE.
- en drop: en=0 during SNOOZE → IDLE next cycle. en=1 with time≠alarm → stays IDLE.
